// File: rtl/thresh_sequencer.sv
// thresh_sequencer: sequences one denoising pass over a block of N
// coefficient pairs held in a dual-bank (a/b) coefficient RAM.
// The SCAN pass finds the largest magnitude across both banks. The APPLY
// pass streams every pair through the external thresholding datapath and
// writes each result back to the address it was read from.
module thresh_sequencer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   n_pairs,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_a,
    input  logic [31:0]       rd_b,
    output logic              dp_valid,
    output logic [31:0]       dp_a,
    output logic [31:0]       dp_b,
    output logic [31:0]       dp_thresh,
    input  logic              dp_out_valid,
    input  logic [31:0]       dp_out_a,
    input  logic [31:0]       dp_out_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_a,
    output logic [31:0]       wr_b,
    output logic              busy,
    output logic              done,
    output logic [31:0]       max_mag
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SCAN_DRAIN,
        APPLY,
        FLUSH,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;

    // Counters are one bit wider than the address so a full 2^ADDR_W block
    // can be counted to completion without wrapping.
    logic [ADDR_W:0] n_reg;
    logic [ADDR_W:0] rd_cnt;
    logic [ADDR_W:0] wr_cnt;

    logic            rd_vld_q;
    logic [31:0]     max_reg;
    logic [31:0]     max_upd;
    logic [31:0]     mag_a;
    logic [31:0]     mag_b;
    logic [31:0]     thresh_reg;
    logic [31:0]     max_mag_reg;
    logic            last_rd;
    logic            in_apply;
    logic            wr_fire;

    assign last_rd  = (rd_cnt == (n_reg - CNT_ONE));
    assign in_apply = (state == APPLY) || (state == FLUSH);

    // A result is written only while the pass still expects one; late or
    // stale results after the Nth write are dropped.
    assign wr_fire  = in_apply && dp_out_valid && (wr_cnt != n_reg);

    // Running-maximum candidate: fold the returning pair into the current max,
    // keeping the current value on a tie.
    always_comb begin
        mag_a   = {1'b0, rd_a[30:0]};
        mag_b   = {1'b0, rd_b[30:0]};
        max_upd = max_reg;
        if (rd_vld_q) begin
            if (mag_a > max_upd) begin
                max_upd = mag_a;
            end
            if (mag_b > max_upd) begin
                max_upd = mag_b;
            end
        end
    end

    // State register; reset aborts any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded strobes.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (n_pairs == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                rd_en = 1'b1;
                if (last_rd) begin
                    state_next = SCAN_DRAIN;
                end
            end
            SCAN_DRAIN: begin
                state_next = APPLY;
            end
            APPLY: begin
                rd_en = 1'b1;
                if (last_rd) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (wr_cnt == n_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Block size, address counters, running max and the published threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg       <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            rd_vld_q    <= 1'b0;
            max_reg     <= '0;
            thresh_reg  <= '0;
            max_mag_reg <= '0;
        end else begin
            rd_vld_q <= rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg   <= n_pairs;
                        max_reg <= '0;
                        rd_cnt  <= '0;
                        wr_cnt  <= '0;
                        if (n_pairs == '0) begin
                            thresh_reg  <= '0;
                            max_mag_reg <= '0;
                        end
                    end
                end
                SCAN: begin
                    max_reg <= max_upd;
                    rd_cnt  <= last_rd ? '0 : (rd_cnt + CNT_ONE);
                end
                SCAN_DRAIN: begin
                    max_reg     <= max_upd;
                    thresh_reg  <= max_upd;
                    max_mag_reg <= max_upd;
                    rd_cnt      <= '0;
                    wr_cnt      <= '0;
                end
                APPLY: begin
                    rd_cnt <= last_rd ? '0 : (rd_cnt + CNT_ONE);
                end
                default: begin
                end
            endcase
            if (wr_fire) begin
                wr_cnt <= wr_cnt + CNT_ONE;
            end
        end
    end

    assign rd_addr   = rd_cnt[ADDR_W-1:0];
    assign wr_addr   = wr_cnt[ADDR_W-1:0];

    // Read data goes to the datapath unmodified in the cycle after each APPLY
    // read; the datapath itself strips the sign.
    assign dp_valid  = rd_vld_q && in_apply;
    assign dp_a      = dp_valid ? rd_a : '0;
    assign dp_b      = dp_valid ? rd_b : '0;
    assign dp_thresh = thresh_reg;

    assign wr_en     = wr_fire;
    assign wr_a      = wr_fire ? dp_out_a : '0;
    assign wr_b      = wr_fire ? dp_out_b : '0;

    assign max_mag   = max_mag_reg;

endmodule
